// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - digit-serial adder/subtractor, DIGIT bits per clock, LSB-first
// Operands are latched on start, then consumed DIGIT bits per cycle through a ripple chain.
module serial_add_sub #(
    parameter int WIDTH = 4,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             s_q, s_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]   result_q, result_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0]       dig_a, dig_b, dig_sum;
    logic [DIGIT:0]         chain;
    logic [WIDTH+DIGIT-1:0] acc_ext;

    // One digit of ripple addition; subtract inverts b and seeds the carry with 1.
    always_comb begin
        dig_a    = a_q[DIGIT-1:0];
        dig_b    = b_q[DIGIT-1:0] ^ {DIGIT{s_q}};
        dig_sum  = '0;
        chain    = '0;
        chain[0] = carry_q;
        for (int i = 0; i < DIGIT; i++) begin
            dig_sum[i]   = dig_a[i] ^ dig_b[i] ^ chain[i];
            chain[i + 1] = (dig_a[i] & dig_b[i]) | (chain[i] & (dig_a[i] ^ dig_b[i]));
        end
        acc_ext = {dig_sum, acc_q};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        s_d      = s_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    s_d     = s;
                    carry_d = s;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = chain[DIGIT];
                acc_d   = acc_ext[WIDTH+DIGIT-1:DIGIT];
                cnt_d   = cnt_q + CW'(1);
                // Visible outputs only change on the final digit, so RUN cycles never glitch them.
                if (cnt_q == CW'(N - 1)) begin
                    state_d  = DONE;
                    result_d = {chain[DIGIT], acc_ext[WIDTH+DIGIT-1:DIGIT]};
                    ovf_d    = chain[DIGIT] ^ chain[DIGIT-1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            s_q      <= s_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign ovf    = ovf_q;
endmodule
